// File: rtl/frame_wr_ctrl.sv
// ---------------------------------------------------------------------------
// frame_wr_ctrl
//
// Purpose:
//   Collects camera pixels into a first-word-fall-through FIFO and drains
//   them to an external memory controller in fixed-length write bursts.
//   The burst start address walks through one frame buffer of FRAME_WORDS
//   words and wraps to 0 after the last burst of a frame, pulsing
//   frame_done. A frame_start pulse resynchronises the writer: the FIFO is
//   flushed, the address returns to 0 and the overflow flag is cleared. If
//   frame_start arrives mid-burst, the burst is allowed to finish first.
//
// Parameters:
//   BURST_LEN   - words per memory write burst (power of 2, >= 2)
//   FIFO_DEPTH  - pixel buffer depth in words (power of 2, >= 2*BURST_LEN)
//   FRAME_WORDS - words per frame (multiple of BURST_LEN)
//   ADDR_W      - memory word-address width
//
// Ports:
//   sys_clk      in   clock for all logic
//   sys_rst      in   asynchronous active-high reset
//   frame_start  in   one-cycle pulse, start of a camera frame
//   pix_valid    in   pixel write strobe
//   pix_data     in   [15:0] RGB565 pixel
//   mem_wr_req   out  burst write request (held until mem_wr_ack)
//   mem_wr_addr  out  [ADDR_W-1:0] burst start word address
//   mem_wr_ack   in   one-cycle request acceptance
//   mem_data_req in   controller pulls one word per asserted cycle (BURST)
//   mem_wr_data  out  [15:0] current FIFO head word
//   overflow     out  sticky pixel-drop flag
//   frame_done   out  one-cycle pulse after the last burst of a frame
// ---------------------------------------------------------------------------
module frame_wr_ctrl #(
  parameter int BURST_LEN   = 16,
  parameter int FIFO_DEPTH  = 64,
  parameter int FRAME_WORDS = 307200,
  parameter int ADDR_W      = 24
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              frame_start,
  input  logic              pix_valid,
  input  logic [15:0]       pix_data,
  output logic              mem_wr_req,
  output logic [ADDR_W-1:0] mem_wr_addr,
  input  logic              mem_wr_ack,
  input  logic              mem_data_req,
  output logic [15:0]       mem_wr_data,
  output logic              overflow,
  output logic              frame_done
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int BEAT_W = $clog2(BURST_LEN);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t              state_reg,      state_next;
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_W:0]      wr_ptr_reg,     wr_ptr_next;
  logic [PTR_W:0]      rd_ptr_reg,     rd_ptr_next;
  logic [BEAT_W-1:0]   beat_reg,       beat_next;
  logic [ADDR_W-1:0]   addr_reg,       addr_next;
  logic                flush_pend_reg, flush_pend_next;
  logic                overflow_reg,   overflow_next;
  logic                done_reg,       done_next;

  // Pixel storage; no reset, contents are only meaningful between pointers.
  logic [15:0]         fifo_mem [FIFO_DEPTH];

  // -------------------------------------------------------------------------
  // Datapath decode
  // -------------------------------------------------------------------------
  logic [PTR_W:0]      level;
  logic                fifo_full;
  logic                fifo_empty;
  logic                pop;
  logic                push;
  logic                drop;
  logic                discard;
  logic                last_beat;
  logic [ADDR_W-1:0]   addr_inc;
  logic                frame_wrap;
  logic                flush_now;

  assign level      = wr_ptr_reg - rd_ptr_reg;
  assign fifo_full  = (level == (PTR_W+1)'(FIFO_DEPTH));
  assign fifo_empty = (level == '0);

  // Pops only happen inside a burst; data requests elsewhere are ignored.
  // The empty guard protects the pointers against a misbehaving controller.
  assign pop        = (state_reg == ST_BURST) && mem_data_req && !fifo_empty;
  assign last_beat  = pop && (beat_reg == BEAT_W'(BURST_LEN - 1));

  // While a flush is pending (or being requested this cycle) incoming pixels
  // belong to a frame that is about to be discarded, so they are silently
  // dropped and do not count as overflow.
  assign discard    = flush_pend_reg || frame_start;

  // A same-cycle pop frees a slot, so a push into a full FIFO is accepted.
  assign push       = pix_valid && !discard && (!fifo_full || pop);
  assign drop       = pix_valid && !discard && fifo_full && !pop;

  assign addr_inc   = addr_reg + ADDR_W'(BURST_LEN);
  assign frame_wrap = (addr_inc == ADDR_W'(FRAME_WORDS));

  // -------------------------------------------------------------------------
  // FIFO storage write and first-word-fall-through read
  // -------------------------------------------------------------------------
  always_ff @(posedge sys_clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg[PTR_W-1:0]] <= pix_data;
    end
  end

  assign mem_wr_data = fifo_mem[rd_ptr_reg[PTR_W-1:0]];

  // -------------------------------------------------------------------------
  // Next-state and datapath update logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    wr_ptr_next     = wr_ptr_reg + {{PTR_W{1'b0}}, push};
    rd_ptr_next     = rd_ptr_reg + {{PTR_W{1'b0}}, pop};
    beat_next       = beat_reg;
    addr_next       = addr_reg;
    flush_pend_next = flush_pend_reg;
    overflow_next   = overflow_reg | drop;
    done_next       = 1'b0;
    flush_now       = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (frame_start) begin
          flush_now = 1'b1;
        end else if (!flush_pend_reg &&
                     (level >= (PTR_W+1)'(BURST_LEN))) begin
          state_next = ST_REQ;
        end
      end

      ST_REQ: begin
        if (frame_start) begin
          // Abandon the request before it is accepted.
          flush_now  = 1'b1;
          state_next = ST_IDLE;
        end else if (mem_wr_ack) begin
          state_next = ST_BURST;
          beat_next  = '0;
        end
      end

      ST_BURST: begin
        // The controller already owns this burst, so a new frame only
        // marks the flush; it is applied when the burst ends.
        if (frame_start) begin
          flush_pend_next = 1'b1;
        end
        if (pop) begin
          beat_next = beat_reg + BEAT_W'(1);
        end
        if (last_beat) begin
          state_next = ST_IDLE;
          addr_next  = frame_wrap ? '0 : addr_inc;
          done_next  = frame_wrap;
          // A frame_start on the very last beat still counts as pending.
          if (flush_pend_reg || frame_start) begin
            flush_now = 1'b1;
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Flush: pushes are blocked whenever a flush is requested, so aligning
    // the read pointer with the current write pointer empties the FIFO,
    // including any word popped on this same edge.
    if (flush_now) begin
      rd_ptr_next     = wr_ptr_reg;
      addr_next       = '0;
      overflow_next   = 1'b0;
      flush_pend_next = 1'b0;
      state_next      = ST_IDLE;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_reg      <= ST_IDLE;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      beat_reg       <= '0;
      addr_reg       <= '0;
      flush_pend_reg <= 1'b0;
      overflow_reg   <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      beat_reg       <= beat_next;
      addr_reg       <= addr_next;
      flush_pend_reg <= flush_pend_next;
      overflow_reg   <= overflow_next;
      done_reg       <= done_next;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // The request is a pure state decode, so it falls the cycle after ack and
  // mem_wr_addr (the address register) cannot move while it is asserted.
  assign mem_wr_req  = (state_reg == ST_REQ);
  assign mem_wr_addr = addr_reg;
  assign overflow    = overflow_reg;
  assign frame_done  = done_reg;

endmodule

// File: tb/tb_frame_wr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_frame_wr_ctrl
//
// Directed testbench for frame_wr_ctrl with BURST_LEN=4, FIFO_DEPTH=8,
// FRAME_WORDS=8. Inputs change 1 ns after the rising edge; outputs are
// sampled at that point, away from the active edge.
// ---------------------------------------------------------------------------
module tb_frame_wr_ctrl;

  localparam int BL = 4;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        frame_start;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic        mem_wr_req;
  logic [23:0] mem_wr_addr;
  logic        mem_wr_ack;
  logic        mem_data_req;
  logic [15:0] mem_wr_data;
  logic        overflow;
  logic        frame_done;

  int tests_run    = 0;
  int tests_failed = 0;

  // Values captured by do_burst, compared by the calling test.
  logic [15:0] cap_data [BL];
  logic [23:0] cap_addr;
  logic [23:0] cap_addr_after;
  logic        cap_req_after_ack;
  logic        cap_req_dropped;
  logic        cap_done;
  logic        cap_timeout;

  frame_wr_ctrl #(
    .BURST_LEN  (4),
    .FIFO_DEPTH (8),
    .FRAME_WORDS(8),
    .ADDR_W     (24)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .frame_start (frame_start),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .mem_wr_req  (mem_wr_req),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_ack  (mem_wr_ack),
    .mem_data_req(mem_data_req),
    .mem_wr_data (mem_wr_data),
    .overflow    (overflow),
    .frame_done  (frame_done)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic push_words(input logic [15:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      pix_valid = 1'b1;
      pix_data  = first + 16'(i);
      tick();
    end
    pix_valid = 1'b0;
  endtask

  task automatic pulse_frame_start();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Serves one burst: waits (bounded) for the request, acks after ack_delay
  // cycles, pulls BL words and records what the DUT presented.
  task automatic do_burst(input int ack_delay);
    cap_timeout     = 1'b0;
    cap_req_dropped = 1'b0;
    for (int i = 0; i < 20 && !mem_wr_req; i++) tick();
    if (!mem_wr_req) begin
      cap_timeout = 1'b1;
      return;
    end
    cap_addr = mem_wr_addr;
    for (int i = 0; i < ack_delay; i++) begin
      tick();
      if (!mem_wr_req || mem_wr_addr !== cap_addr) cap_req_dropped = 1'b1;
    end
    mem_wr_ack = 1'b1;
    tick();
    mem_wr_ack        = 1'b0;
    cap_req_after_ack = mem_wr_req;
    mem_data_req      = 1'b1;
    for (int i = 0; i < BL; i++) begin
      cap_data[i] = mem_wr_data;
      tick();
    end
    mem_data_req   = 1'b0;
    cap_done       = frame_done;
    cap_addr_after = mem_wr_addr;
    $display("[TB] burst addr=%0d data=%h %h %h %h next_addr=%0d frame_done=%0b",
             cap_addr, cap_data[0], cap_data[1], cap_data[2], cap_data[3],
             cap_addr_after, cap_done);
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    frame_start = 1'b0; pix_valid = 1'b0; pix_data = '0;
    mem_wr_ack = 1'b0; mem_data_req = 1'b0;
    tick(); tick();
    tests_run++;
    if ({mem_wr_req, overflow, frame_done} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_flags: got req/ovf/done=%b expected 000",
               {mem_wr_req, overflow, frame_done});
    end
    tests_run++;
    if (mem_wr_addr !== 24'd0) begin
      tests_failed++;
      $display("FAIL reset_addr: got %0d expected 0", mem_wr_addr);
    end
    sys_rst = 1'b0;
    tick();
    $display("[TB] reset released");
  endtask

  task automatic test_single_burst();
    push_words(16'h0001, 4);
    do_burst(2);
    tests_run++;
    if (cap_timeout) begin
      tests_failed++;
      $display("FAIL single_req_timeout: got no mem_wr_req expected request");
      return;
    end
    tests_run++;
    if (cap_addr !== 24'd0) begin
      tests_failed++;
      $display("FAIL single_addr: got %0d expected 0", cap_addr);
    end
    tests_run++;
    if (cap_req_dropped) begin
      tests_failed++;
      $display("FAIL single_req_hold: got req/addr unstable before ack expected stable");
    end
    tests_run++;
    if (cap_req_after_ack !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_req_after_ack: got %b expected 0", cap_req_after_ack);
    end
    for (int i = 0; i < BL; i++) begin
      tests_run++;
      if (cap_data[i] !== 16'(i + 1)) begin
        tests_failed++;
        $display("FAIL single_data[%0d]: got %h expected %h", i, cap_data[i], 16'(i + 1));
      end
    end
    tests_run++;
    if (cap_addr_after !== 24'd4 || cap_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_next: got addr=%0d done=%b expected addr=4 done=0",
               cap_addr_after, cap_done);
    end
  endtask

  task automatic test_frame_wrap();
    pulse_frame_start();
    tests_run++;
    if (mem_wr_addr !== 24'd0) begin
      tests_failed++;
      $display("FAIL wrap_restart_addr: got %0d expected 0", mem_wr_addr);
    end
    push_words(16'h0011, 8);
    do_burst(0);
    tests_run++;
    if (cap_timeout || cap_addr !== 24'd0 || cap_done !== 1'b0 ||
        cap_data[0] !== 16'h0011 || cap_data[3] !== 16'h0014) begin
      tests_failed++;
      $display("FAIL wrap_burst1: got to=%b addr=%0d done=%b d0=%h d3=%h expected to=0 addr=0 done=0 d0=0011 d3=0014",
               cap_timeout, cap_addr, cap_done, cap_data[0], cap_data[3]);
    end
    do_burst(1);
    tests_run++;
    if (cap_timeout || cap_addr !== 24'd4 ||
        cap_data[0] !== 16'h0015 || cap_data[3] !== 16'h0018) begin
      tests_failed++;
      $display("FAIL wrap_burst2: got to=%b addr=%0d d0=%h d3=%h expected to=0 addr=4 d0=0015 d3=0018",
               cap_timeout, cap_addr, cap_data[0], cap_data[3]);
    end
    tests_run++;
    if (cap_done !== 1'b1 || cap_addr_after !== 24'd0) begin
      tests_failed++;
      $display("FAIL wrap_done: got done=%b addr=%0d expected done=1 addr=0",
               cap_done, cap_addr_after);
    end
    tick();
    tests_run++;
    if (frame_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL wrap_done_width: got %b expected 0", frame_done);
    end
  endtask

  task automatic test_overflow();
    push_words(16'h0001, 8);
    tests_run++;
    if (overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_after_8: got %b expected 0", overflow);
    end
    push_words(16'h0009, 1);
    tests_run++;
    if (overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_after_9: got %b expected 1", overflow);
    end
    push_words(16'h000A, 1);
    do_burst(0);
    for (int i = 0; i < BL; i++) begin
      tests_run++;
      if (cap_timeout || cap_data[i] !== 16'(i + 1)) begin
        tests_failed++;
        $display("FAIL ovf_data[%0d]: got %h expected %h", i, cap_data[i], 16'(i + 1));
      end
    end
    do_burst(0);
    for (int i = 0; i < BL; i++) begin
      tests_run++;
      if (cap_timeout || cap_data[i] !== 16'(i + 5)) begin
        tests_failed++;
        $display("FAIL ovf_data[%0d]: got %h expected %h", i + 4, cap_data[i], 16'(i + 5));
      end
    end
    tick(); tick(); tick();
    tests_run++;
    if (mem_wr_req !== 1'b0 || overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_lost_words: got req=%b ovf=%b expected req=0 ovf=1",
               mem_wr_req, overflow);
    end
    pulse_frame_start();
    tests_run++;
    if (overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_clear: got %b expected 0", overflow);
    end
  endtask

  task automatic test_flush_in_burst();
    logic [15:0] got [BL];
    logic        timed_out;
    push_words(16'h0021, 6);
    timed_out = 1'b0;
    for (int i = 0; i < 20 && !mem_wr_req; i++) tick();
    if (!mem_wr_req) timed_out = 1'b1;
    mem_wr_ack = 1'b1;
    tick();
    mem_wr_ack   = 1'b0;
    mem_data_req = 1'b1;
    for (int i = 0; i < BL; i++) begin
      got[i]      = mem_wr_data;
      frame_start = (i == 1);
      pix_valid   = (i >= 1);
      pix_data    = 16'h0099;
      tick();
    end
    frame_start  = 1'b0;
    pix_valid    = 1'b0;
    mem_data_req = 1'b0;
    $display("[TB] flush-in-burst data=%h %h %h %h addr=%0d ovf=%b",
             got[0], got[1], got[2], got[3], mem_wr_addr, overflow);
    for (int i = 0; i < BL; i++) begin
      tests_run++;
      if (timed_out || got[i] !== 16'(16'h0021 + i)) begin
        tests_failed++;
        $display("FAIL flushb_data[%0d]: got %h expected %h", i, got[i], 16'(16'h0021 + i));
      end
    end
    tests_run++;
    if (mem_wr_addr !== 24'd0 || overflow !== 1'b0 || frame_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL flushb_state: got addr=%0d ovf=%b done=%b expected 0 0 0",
               mem_wr_addr, overflow, frame_done);
    end
    tick(); tick(); tick();
    tests_run++;
    if (mem_wr_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL flushb_empty: got req=%b expected 0", mem_wr_req);
    end
    push_words(16'h0031, 4);
    do_burst(0);
    tests_run++;
    if (cap_timeout || cap_addr !== 24'd0 || cap_data[0] !== 16'h0031 ||
        cap_data[3] !== 16'h0034) begin
      tests_failed++;
      $display("FAIL flushb_after: got to=%b addr=%0d d0=%h d3=%h expected to=0 addr=0 d0=0031 d3=0034",
               cap_timeout, cap_addr, cap_data[0], cap_data[3]);
    end
  endtask

  task automatic test_flush_in_req();
    push_words(16'h0041, 4);
    for (int i = 0; i < 20 && !mem_wr_req; i++) tick();
    tests_run++;
    if (mem_wr_req !== 1'b1 || mem_wr_addr !== 24'd4) begin
      tests_failed++;
      $display("FAIL flushr_req: got req=%b addr=%0d expected req=1 addr=4",
               mem_wr_req, mem_wr_addr);
    end
    pulse_frame_start();
    tests_run++;
    if (mem_wr_req !== 1'b0 || mem_wr_addr !== 24'd0) begin
      tests_failed++;
      $display("FAIL flushr_drop: got req=%b addr=%0d expected req=0 addr=0",
               mem_wr_req, mem_wr_addr);
    end
    tick(); tick(); tick();
    tests_run++;
    if (mem_wr_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL flushr_empty: got req=%b expected 0", mem_wr_req);
    end
    push_words(16'h0051, 4);
    do_burst(0);
    tests_run++;
    if (cap_timeout || cap_addr !== 24'd0 || cap_data[0] !== 16'h0051 ||
        cap_data[3] !== 16'h0054) begin
      tests_failed++;
      $display("FAIL flushr_after: got to=%b addr=%0d d0=%h d3=%h expected to=0 addr=0 d0=0051 d3=0054",
               cap_timeout, cap_addr, cap_data[0], cap_data[3]);
    end
  endtask

  task automatic test_reset_mid_burst();
    push_words(16'h0061, 4);
    for (int i = 0; i < 20 && !mem_wr_req; i++) tick();
    mem_wr_ack = 1'b1;
    tick();
    mem_wr_ack   = 1'b0;
    mem_data_req = 1'b1;
    tick(); tick();
    tests_run++;
    if (mem_wr_addr !== 24'd4) begin
      tests_failed++;
      $display("FAIL rst_pre_addr: got %0d expected 4", mem_wr_addr);
    end
    sys_rst      = 1'b1;
    mem_data_req = 1'b0;
    #1;
    tests_run++;
    if ({mem_wr_req, overflow, frame_done} !== 3'b000 || mem_wr_addr !== 24'd0) begin
      tests_failed++;
      $display("FAIL rst_async: got req/ovf/done=%b addr=%0d expected 000 addr=0",
               {mem_wr_req, overflow, frame_done}, mem_wr_addr);
    end
    tick();
    sys_rst = 1'b0;
    tick(); tick();
    tests_run++;
    if (frame_done !== 1'b0 || mem_wr_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_no_complete: got done=%b req=%b expected 0 0",
               frame_done, mem_wr_req);
    end
    push_words(16'h0071, 4);
    do_burst(0);
    tests_run++;
    if (cap_timeout || cap_addr !== 24'd0 || cap_data[0] !== 16'h0071 ||
        cap_data[3] !== 16'h0074 || cap_addr_after !== 24'd4) begin
      tests_failed++;
      $display("FAIL rst_after: got to=%b addr=%0d d0=%h d3=%h next=%0d expected to=0 addr=0 d0=0071 d3=0074 next=4",
               cap_timeout, cap_addr, cap_data[0], cap_data[3], cap_addr_after);
    end
  endtask

  task automatic test_data_req_ignored();
    push_words(16'h0081, 4);
    for (int i = 0; i < 20 && !mem_wr_req; i++) tick();
    mem_data_req = 1'b1;
    tick(); tick(); tick();
    mem_data_req = 1'b0;
    do_burst(0);
    for (int i = 0; i < BL; i++) begin
      tests_run++;
      if (cap_timeout || cap_data[i] !== 16'(16'h0081 + i)) begin
        tests_failed++;
        $display("FAIL ignore_data[%0d]: got %h expected %h", i, cap_data[i], 16'(16'h0081 + i));
      end
    end
    tests_run++;
    if (cap_addr !== 24'd4 || cap_done !== 1'b1 || cap_addr_after !== 24'd0) begin
      tests_failed++;
      $display("FAIL ignore_wrap: got addr=%0d done=%b next=%0d expected 4 1 0",
               cap_addr, cap_done, cap_addr_after);
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_frame_wrap();
    test_overflow();
    test_flush_in_burst();
    test_flush_in_req();
    test_reset_mid_burst();
    test_data_req_ignored();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
